// File: rtl/timekeeper_counter.sv
// Time-of-day counter: divides the tick clock into seconds and keeps sec/min/hr
// in 24h or 12h (AM/PM) form, with in-place field setting and rollover strobes.
module timekeeper_counter #(
  parameter int unsigned TICK_DIV = 10000,
  parameter bit          MODE_12H = 1'b0,
  parameter int unsigned SUB_W    = 14
) (
  input  logic             clk_10000Hz,
  input  logic             rst,
  input  logic             enable,
  input  logic             setting_enable,
  input  logic [1:0]       field_sel,
  input  logic             inc_pulse,
  input  logic             dec_pulse,
  output logic [SUB_W-1:0] sub_sec_out,
  output logic [5:0]       sec_out,
  output logic [5:0]       min_out,
  output logic [4:0]       hr_out,
  output logic             pm_out,
  output logic             sec_tick,
  output logic             day_wrap
);

  typedef enum logic [1:0] {
    FIELD_HR   = 2'd0,
    FIELD_MIN  = 2'd1,
    FIELD_SEC  = 2'd2,
    FIELD_NONE = 2'd3
  } field_e;

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICK_DIV - 1);
  localparam logic [4:0]       HR_MIN   = MODE_12H ? 5'd1  : 5'd0;
  localparam logic [4:0]       HR_MAX   = MODE_12H ? 5'd12 : 5'd23;
  localparam logic [4:0]       HR_RESET = MODE_12H ? 5'd12 : 5'd0;

  logic [SUB_W-1:0] sub_nxt;
  logic [5:0]       sec_nxt;
  logic [5:0]       min_nxt;
  logic [4:0]       hr_nxt;
  logic             pm_nxt;
  logic             tick_nxt;
  logic             wrap_nxt;

  // Base-60 step in either direction with wrap at both ends.
  function automatic logic [5:0] step60(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  // NOTE: every next-state signal gets its hold value first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    sub_nxt  = sub_sec_out;
    sec_nxt  = sec_out;
    min_nxt  = min_out;
    hr_nxt   = hr_out;
    pm_nxt   = pm_out;
    tick_nxt = 1'b0;
    wrap_nxt = 1'b0;

    if (setting_enable) begin
      if (inc_pulse ^ dec_pulse) begin
        unique case (field_e'(field_sel))
          FIELD_SEC: begin
            sec_nxt = step60(sec_out, inc_pulse);
            sub_nxt = '0;
          end
          FIELD_MIN: min_nxt = step60(min_out, inc_pulse);
          FIELD_HR: begin
            if (inc_pulse) begin
              hr_nxt = (hr_out == HR_MAX) ? HR_MIN : hr_out + 5'd1;
              if (MODE_12H && hr_out == 5'd11) pm_nxt = ~pm_out;
            end else begin
              hr_nxt = (hr_out == HR_MIN) ? HR_MAX : hr_out - 5'd1;
              if (MODE_12H && hr_out == 5'd12) pm_nxt = ~pm_out;
            end
          end
          FIELD_NONE: ;
        endcase
      end
    end else if (enable) begin
      if (sub_sec_out == SUB_LAST) begin
        sub_nxt  = '0;
        tick_nxt = 1'b1;
        sec_nxt  = step60(sec_out, 1'b1);
        if (sec_out == 6'd59) begin
          min_nxt = step60(min_out, 1'b1);
          if (min_out == 6'd59) begin
            hr_nxt = (hr_out == HR_MAX) ? HR_MIN : hr_out + 5'd1;
            if (MODE_12H) begin
              // 11:59:59 flips the meridiem; PM->AM is the midnight rollover.
              if (hr_out == 5'd11) begin
                pm_nxt   = ~pm_out;
                wrap_nxt = pm_out;
              end
            end else begin
              wrap_nxt = (hr_out == HR_MAX);
            end
          end
        end
      end else begin
        sub_nxt = sub_sec_out + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk_10000Hz) begin
    if (rst) begin
      sub_sec_out <= '0;
      sec_out     <= '0;
      min_out     <= '0;
      hr_out      <= HR_RESET;
      pm_out      <= 1'b0;
      sec_tick    <= 1'b0;
      day_wrap    <= 1'b0;
    end else begin
      sub_sec_out <= sub_nxt;
      sec_out     <= sec_nxt;
      min_out     <= min_nxt;
      hr_out      <= hr_nxt;
      pm_out      <= pm_nxt;
      sec_tick    <= tick_nxt;
      day_wrap    <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_timekeeper_counter.sv
// Directed bench for timekeeper_counter: a 24h and a 12h instance share stimulus;
// expected values are queued per step and popped/compared after the edge.
module tb_timekeeper_counter;

  localparam int unsigned TD = 4;
  localparam int unsigned SW = 2;

  logic          clk_10000Hz = 1'b0;
  logic          rst, enable, setting_enable, inc_pulse, dec_pulse;
  logic [1:0]    field_sel;
  logic [SW-1:0] a_sub, b_sub;
  logic [5:0]    a_sec, a_min, b_sec, b_min;
  logic [4:0]    a_hr, b_hr;
  logic          a_pm, b_pm, a_tick, b_tick, a_wrap, b_wrap;

  always #5 clk_10000Hz = ~clk_10000Hz;

  timekeeper_counter #(.TICK_DIV(TD), .MODE_12H(1'b0), .SUB_W(SW)) dut24 (
    .clk_10000Hz(clk_10000Hz), .rst(rst), .enable(enable), .setting_enable(setting_enable),
    .field_sel(field_sel), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .sub_sec_out(a_sub), .sec_out(a_sec), .min_out(a_min), .hr_out(a_hr),
    .pm_out(a_pm), .sec_tick(a_tick), .day_wrap(a_wrap)
  );

  timekeeper_counter #(.TICK_DIV(TD), .MODE_12H(1'b1), .SUB_W(SW)) dut12 (
    .clk_10000Hz(clk_10000Hz), .rst(rst), .enable(enable), .setting_enable(setting_enable),
    .field_sel(field_sel), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .sub_sec_out(b_sub), .sec_out(b_sec), .min_out(b_min), .hr_out(b_hr),
    .pm_out(b_pm), .sec_tick(b_tick), .day_wrap(b_wrap)
  );

  typedef enum {
    A_SUB, A_SEC, A_MIN, A_HR, A_PM, A_TICK, A_WRAP,
    B_SUB, B_SEC, B_MIN, B_HR, B_PM, B_TICK, B_WRAP
  } sig_e;

  typedef struct {
    string       tag;
    sig_e        id;
    logic [31:0] val;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad   = 0;

  function automatic logic [31:0] observe(sig_e id);
    case (id)
      A_SUB:   return 32'(a_sub);
      A_SEC:   return 32'(a_sec);
      A_MIN:   return 32'(a_min);
      A_HR:    return 32'(a_hr);
      A_PM:    return 32'(a_pm);
      A_TICK:  return 32'(a_tick);
      A_WRAP:  return 32'(a_wrap);
      B_SUB:   return 32'(b_sub);
      B_SEC:   return 32'(b_sec);
      B_MIN:   return 32'(b_min);
      B_HR:    return 32'(b_hr);
      B_PM:    return 32'(b_pm);
      B_TICK:  return 32'(b_tick);
      default: return 32'(b_wrap);
    endcase
  endfunction

  task automatic push(input string tag, input sig_e id, input int unsigned val);
    item_t it;
    it.tag = $sformatf("%s.%s", tag, id.name());
    it.id  = id;
    it.val = 32'(val);
    sb.push_back(it);
  endtask

  // Expected state of both instances; the 24h pm flag is always 0.
  task automatic exp_all(input string tag, input int unsigned sub, input int unsigned sec,
                         input int unsigned mn, input int unsigned hr_a, input int unsigned hr_b,
                         input int unsigned pm_b, input int unsigned tick, input int unsigned wrap);
    push(tag, A_SUB, sub);  push(tag, A_SEC, sec);   push(tag, A_MIN, mn);
    push(tag, A_HR, hr_a);  push(tag, A_PM, 0);      push(tag, A_TICK, tick);
    push(tag, A_WRAP, wrap);
    push(tag, B_SUB, sub);  push(tag, B_SEC, sec);   push(tag, B_MIN, mn);
    push(tag, B_HR, hr_b);  push(tag, B_PM, pm_b);   push(tag, B_TICK, tick);
    push(tag, B_WRAP, wrap);
  endtask

  task automatic check();
    item_t       it;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = observe(it.id);
      total++;
      assert (obs === it.val) else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", it.tag, obs, it.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_10000Hz);
    #1;
    check();
  endtask

  task automatic drive(input logic r, input logic e, input logic s, input logic [1:0] f,
                       input logic i, input logic d);
    rst = r; enable = e; setting_enable = s; field_sel = f; inc_pulse = i; dec_pulse = d;
  endtask

  initial begin
    drive(1, 0, 0, 2'd3, 0, 0);
    #1;
    exp_all("reset", 0, 0, 0, 0, 12, 0, 0, 0);
    step();

    // Free run: sub_sec 1,2,3,0 with the second carry on the 4th edge.
    drive(0, 1, 0, 2'd3, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      exp_all($sformatf("run%0d", i), i % TD, (i >= 4) ? 1 : 0, 0, 0, 12, 0,
              (i == 4) ? 1 : 0, 0);
      step();
    end

    // Setting freezes time; a sec change clears sub_sec; counting resumes from there.
    drive(0, 1, 1, 2'd2, 0, 0);
    exp_all("freeze", 2, 1, 0, 0, 12, 0, 0, 0);
    step();
    drive(0, 1, 1, 2'd2, 1, 0);
    exp_all("set_sec_inc", 0, 2, 0, 0, 12, 0, 0, 0);
    step();
    drive(0, 1, 0, 2'd3, 0, 0);
    exp_all("resume", 1, 2, 0, 0, 12, 0, 0, 0);
    step();

    // Minute wrap both ways, simultaneous pulses, and no field selected.
    drive(0, 1, 1, 2'd1, 0, 1);
    exp_all("min_dec_wrap", 1, 2, 59, 0, 12, 0, 0, 0);
    step();
    drive(0, 1, 1, 2'd1, 1, 0);
    exp_all("min_inc_wrap", 1, 2, 0, 0, 12, 0, 0, 0);
    step();
    drive(0, 1, 1, 2'd1, 1, 1);
    exp_all("min_both", 1, 2, 0, 0, 12, 0, 0, 0);
    step();
    drive(0, 1, 1, 2'd3, 1, 0);
    exp_all("field_none", 1, 2, 0, 0, 12, 0, 0, 0);
    step();

    // Set 23:59:59 (24h) / 11:59:59 PM (12h), then run into midnight.
    drive(0, 1, 1, 2'd0, 0, 1);
    exp_all("hr_dec_wrap", 1, 2, 0, 23, 11, 1, 0, 0);
    step();
    drive(0, 1, 1, 2'd1, 0, 1);
    exp_all("min_dec", 1, 2, 59, 23, 11, 1, 0, 0);
    step();
    drive(0, 1, 1, 2'd2, 0, 1);
    for (int i = 1; i <= 3; i++) begin
      exp_all($sformatf("sec_dec%0d", i), 0, (i == 3) ? 59 : 2 - i, 59, 23, 11, 1, 0, 0);
      step();
    end
    drive(0, 1, 0, 2'd3, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      if (i < 4)
        exp_all($sformatf("midnight%0d", i), i, 59, 59, 23, 11, 1, 0, 0);
      else
        exp_all($sformatf("midnight%0d", i), i % TD, 0, 0, 0, 12, 0,
                (i == 4) ? 1 : 0, (i == 4) ? 1 : 0);
      step();
    end

    // 12h hour stepping through the AM/PM boundary.
    drive(1, 0, 0, 2'd3, 0, 0);
    exp_all("reset2", 0, 0, 0, 0, 12, 0, 0, 0);
    step();
    drive(0, 0, 1, 2'd0, 1, 0);
    for (int k = 1; k <= 11; k++) begin
      exp_all($sformatf("hr_inc%0d", k), 0, 0, 0, k, k, 0, 0, 0);
      step();
    end
    exp_all("hr_inc12", 0, 0, 0, 12, 12, 1, 0, 0);
    step();
    drive(0, 0, 1, 2'd0, 0, 1);
    exp_all("hr_dec11", 0, 0, 0, 11, 11, 0, 0, 0);
    step();

    // Reset lands on the edge that would otherwise roll the second over.
    drive(0, 0, 1, 2'd2, 0, 1);
    exp_all("sec_to59", 0, 59, 0, 11, 11, 0, 0, 0);
    step();
    drive(0, 1, 0, 2'd3, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      exp_all($sformatf("pre_rst%0d", i), i, 59, 0, 11, 11, 0, 0, 0);
      step();
    end
    drive(1, 1, 0, 2'd3, 0, 0);
    exp_all("rst_rollover", 0, 0, 0, 0, 12, 0, 0, 0);
    step();
    drive(0, 0, 0, 2'd3, 0, 0);
    exp_all("idle", 0, 0, 0, 0, 12, 0, 0, 0);
    step();
    exp_all("idle2", 0, 0, 0, 0, 12, 0, 0, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
